// File: rtl/id_pkg.sv
// Shared definitions for the student-ID digit sequencer and its receive-side checker.
// Holds the FSM state encoding, error codes and the fixed ID digit sequence so that
// both ends of the link always agree on the expected digits.
package id_pkg;

  localparam int unsigned NDigits = 9;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StMatching = 2'b01,
    StDone     = 2'b10,
    StError    = 2'b11
  } state_e;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrMismatch = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;

  // Index 0 sits in the least-significant nibble: 5,0,1,1,5,2,0,4,8.
  localparam logic [NDigits-1:0][3:0] IdDigits = {
    4'd8, 4'd4, 4'd0, 4'd2, 4'd5, 4'd1, 4'd1, 4'd0, 4'd5
  };

endpackage

// File: rtl/id_sequence_checker_if.sv
// Digit stream and status bundle between the sequencer side and the checker.
//   master: drives digit_in, digit_valid, clear; observes status.
//   slave : the checker; consumes digits, drives progress/busy/match/error/err_code.
interface id_sequence_checker_if;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       clear;
  logic [3:0] progress;
  logic       busy;
  logic       match;
  logic       error;
  logic [1:0] err_code;

  modport master (
    output digit_in, digit_valid, clear,
    input  progress, busy, match, error, err_code
  );

  modport slave (
    input  digit_in, digit_valid, clear,
    output progress, busy, match, error, err_code
  );
endinterface

// File: rtl/id_digit_rom.sv
// Combinational lookup from sequence index to expected ID digit.
//   idx_i   : 4-bit position in the sequence
//   digit_o : expected digit, 0 for any index past the end of the sequence
module id_digit_rom
  import id_pkg::*;
#(
  parameter int unsigned NumDigits = NDigits
) (
  input  logic [3:0] idx_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = 4'd0;
    if ((32'(idx_i) < NumDigits) && (32'(idx_i) < NDigits)) begin
      digit_o = IdDigits[idx_i];
    end
  end

endmodule

// File: rtl/id_sequence_checker.sv
// Checks a stream of valid-qualified digits against the fixed ID sequence.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   bus (slave): digit_in/digit_valid/clear in; progress, busy, match (1-cycle pulse),
//                sticky error and err_code out. All outputs are registered.
module id_sequence_checker
  import id_pkg::*;
#(
  parameter int unsigned NDigitsP      = NDigits,
  parameter int unsigned TimeoutCycles = 16
) (
  input logic               clk,
  input logic               reset,
  id_sequence_checker_if.slave bus
);

  localparam int unsigned TimerW = $clog2(TimeoutCycles) + 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles - 1);
  localparam logic [3:0] LastIdx = 4'(NDigitsP - 1);
  localparam logic [3:0] DoneIdx = 4'(NDigitsP);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        err_q, err_d;
  logic              busy_q, match_q, error_q;

  logic [3:0] rom_idx;
  logic [3:0] exp_digit;
  logic       hit;

  // Outside MATCHING the next valid digit is always the first of a new sequence.
  assign rom_idx = (state_q == StMatching) ? idx_q : 4'd0;

  id_digit_rom #(
    .NumDigits(NDigitsP)
  ) u_rom (
    .idx_i  (rom_idx),
    .digit_o(exp_digit)
  );

  assign hit = (bus.digit_in == exp_digit);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    err_d   = err_q;
    if (bus.clear) begin
      state_d = StIdle;
      idx_d   = 4'd0;
      timer_d = '0;
      err_d   = ErrNone;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          idx_d   = 4'd0;
          timer_d = '0;
          state_d = StIdle;
          if (bus.digit_valid) begin
            if (hit) begin
              state_d = StMatching;
              idx_d   = 4'd1;
            end else begin
              state_d = StError;
              err_d   = ErrMismatch;
            end
          end
        end
        StMatching: begin
          if (bus.digit_valid) begin
            if (!hit) begin
              state_d = StError;
              err_d   = ErrMismatch;
            end else if (idx_q == LastIdx) begin
              state_d = StDone;
              idx_d   = DoneIdx;
            end else begin
              idx_d   = idx_q + 4'd1;
              timer_d = '0;
            end
          end else if (timer_q >= TimerMax) begin
            state_d = StError;
            err_d   = ErrTimeout;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StError: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      timer_q <= '0;
      err_q   <= ErrNone;
      busy_q  <= 1'b0;
      match_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      busy_q  <= (state_d == StMatching);
      match_q <= (state_d == StDone);
      error_q <= (state_d == StError);
    end
  end

  assign bus.progress = idx_q;
  assign bus.busy     = busy_q;
  assign bus.match    = match_q;
  assign bus.error    = error_q;
  assign bus.err_code = err_q;

endmodule

// File: tb/tb_id_sequence_checker.sv
module tb_id_sequence_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  id_sequence_checker_if bus ();

  id_sequence_checker dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [3:0] digit;
    logic       clr;
    logic [8:0] exp;  // {progress, busy, match, error, err_code}
  } vec_t;

  vec_t vecs[$];
  logic [3:0] id_d [9] = '{4'd5, 4'd0, 4'd1, 4'd1, 4'd5, 4'd2, 4'd0, 4'd4, 4'd8};

  function automatic logic [8:0] outs();
    return {bus.progress, bus.busy, bus.match, bus.error, bus.err_code};
  endfunction

  function automatic logic [8:0] ex(int p, bit b, bit m, bit e, logic [1:0] c);
    return {4'(p), b, m, e, c};
  endfunction

  function automatic vec_t mk(logic v, logic [3:0] d, logic c, logic [8:0] e);
    vec_t r;
    r.valid = v; r.digit = d; r.clr = c; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got p=%0d b=%b m=%b e=%b c=%b, want p=%0d b=%b m=%b e=%b c=%b",
               name, got[8:5], got[4], got[3], got[2], got[1:0],
               exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic c);
    bus.digit_valid = v;
    bus.digit_in    = d;
    bus.clear       = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int match_seen;

  initial begin
    drive(1'b0, 4'd0, 1'b0);
    #12;
    check("reset", outs(), ex(0, 0, 0, 0, 2'b00));
    @(negedge clk);
    reset = 1'b1;

    // Full sequence, then idle.
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(1, id_d[i], 0, ex(i + 1, i < 8, i == 8, 0, 2'b00)));
    vecs.push_back(mk(0, 0, 0, ex(0, 0, 0, 0, 2'b00)));
    vecs.push_back(mk(0, 0, 0, ex(0, 0, 0, 0, 2'b00)));
    // Mismatch on 4th digit, ignored digit in ERROR, clear.
    vecs.push_back(mk(1, 5, 0, ex(1, 1, 0, 0, 2'b00)));
    vecs.push_back(mk(1, 0, 0, ex(2, 1, 0, 0, 2'b00)));
    vecs.push_back(mk(1, 1, 0, ex(3, 1, 0, 0, 2'b00)));
    vecs.push_back(mk(1, 3, 0, ex(3, 0, 0, 1, 2'b01)));
    vecs.push_back(mk(1, 5, 0, ex(3, 0, 0, 1, 2'b01)));
    vecs.push_back(mk(0, 0, 1, ex(0, 0, 0, 0, 2'b00)));
    // Mismatch in IDLE.
    vecs.push_back(mk(1, 7, 0, ex(0, 0, 0, 1, 2'b01)));
    vecs.push_back(mk(0, 0, 1, ex(0, 0, 0, 0, 2'b00)));
    // Clear wins over a mismatching digit in MATCHING.
    vecs.push_back(mk(1, 5, 0, ex(1, 1, 0, 0, 2'b00)));
    vecs.push_back(mk(1, 7, 1, ex(0, 0, 0, 0, 2'b00)));
    vecs.push_back(mk(0, 0, 0, ex(0, 0, 0, 0, 2'b00)));

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].digit, vecs[i].clr);
      step();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // 15 idle cycles between digits is still within the timeout.
    drive(1, 5, 0); step();
    drive(1, 0, 0); step();
    drive(0, 0, 0);
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("gap15_%0d", k), outs(), ex(2, 1, 0, 0, 2'b00));
    end
    drive(1, 1, 0); step();
    check("gap15_resume", outs(), ex(3, 1, 0, 0, 2'b00));
    drive(0, 0, 1); step();
    check("gap15_clear", outs(), ex(0, 0, 0, 0, 2'b00));

    // 16 idle cycles trips the timeout.
    drive(1, 5, 0); step();
    drive(1, 0, 0); step();
    drive(0, 0, 0);
    for (int k = 0; k < 15; k++) step();
    check("gap_pre_to", outs(), ex(2, 1, 0, 0, 2'b00));
    step();
    check("timeout", outs(), ex(2, 0, 0, 1, 2'b10));
    drive(0, 0, 1); step();
    check("timeout_clear", outs(), ex(0, 0, 0, 0, 2'b00));

    // Back-to-back sequences, second starts in the DONE cycle.
    match_seen = 0;
    for (int k = 0; k < 18; k++) begin
      drive(1, id_d[k % 9], 0);
      step();
      if (bus.match) match_seen++;
      check($sformatf("b2b_%0d", k), outs(),
            ex((k == 8 || k == 17) ? 9 : (k % 9) + 1, !(k == 8 || k == 17),
               (k == 8 || k == 17), 0, 2'b00));
    end
    drive(0, 0, 0); step();
    check("b2b_idle", outs(), ex(0, 0, 0, 0, 2'b00));
    n_cmp++;
    if (match_seen != 2) begin
      n_bad++;
      $display("FAIL b2b_matches: got %0d pulses, want 2", match_seen);
    end

    // Asynchronous reset mid-sequence.
    for (int k = 0; k < 4; k++) begin
      drive(1, id_d[k], 0); step();
    end
    check("pre_reset", outs(), ex(4, 1, 0, 0, 2'b00));
    drive(0, 0, 0);
    #2 reset = 1'b0;
    #1 check("async_reset", outs(), ex(0, 0, 0, 0, 2'b00));
    step();
    check("reset_held", outs(), ex(0, 0, 0, 0, 2'b00));
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(1, id_d[k], 0); step();
    end
    check("post_reset_match", outs(), ex(9, 0, 1, 0, 2'b00));
    drive(0, 0, 0); step();
    check("post_reset_idle", outs(), ex(0, 0, 0, 0, 2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_sequence_checker.md
Name: id_sequence_checker

Overview:
Receive-side counterpart of the student-ID digit sequencer. Accepts a stream of 4-bit digits qualified by a valid strobe and checks them in order against the fixed 9-digit ID sequence. Reports progress, a one-cycle match pulse on a complete correct sequence, and a sticky error with cause (mismatch or inter-digit timeout). Sits between the sequencer's digit output and the processor status logic.

Parameters:
N_DIGITS, 9, number of digits in the expected sequence (index width fixed at 4 bits, so N_DIGITS <= 15)
TIMEOUT_CYCLES, 16, maximum cycles allowed between consecutive valid digits once a sequence has started

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
digit_in  input  4  received digit
digit_valid  input  1  digit_in qualifier, one digit per high cycle
clear  input  1  synchronous abort/acknowledge, returns to IDLE
progress  output  4  count of digits matched so far in current sequence
busy  output  1  high while a sequence is in progress (state MATCHING)
match  output  1  one-cycle pulse: full sequence received correctly
error  output  1  sticky error flag, held until clear
err_code  output  2  00 none, 01 digit mismatch, 10 timeout, 11 reserved (never driven)

Behaviour:
- Reset (reset=0, async): state IDLE, idx=0, timer=0; progress=0, busy=0, match=0, error=0, err_code=00.
- Expected sequence, index 0..8: 5,0,1,1,5,2,0,4,8.
- States: IDLE, MATCHING, DONE, ERROR. All outputs registered.
- clear=1: next state IDLE, idx=0, timer=0, error/err_code cleared. Highest priority over digit_valid and timeout in every state.
- IDLE:
  - digit_valid and digit_in==EXP[0]: idx=1, go MATCHING.
  - digit_valid and mismatch: go ERROR, err_code=01.
  - No valid: stay in IDLE. No timeout in IDLE.
- MATCHING, digit_valid:
  - Compare digit_in against EXP[idx].
  - Equal and idx<N_DIGITS-1: idx++, timer=0.
  - Equal and idx==N_DIGITS-1: go DONE, idx=N_DIGITS.
  - Unequal: go ERROR, err_code=01, idx frozen.
- MATCHING, no digit_valid:
  - timer++.
  - When timer reaches TIMEOUT_CYCLES-1 with no valid that cycle: go ERROR, err_code=10.
  - A valid on the boundary cycle wins over the timeout.
- DONE (one cycle):
  - match=1 and progress=N_DIGITS during this cycle; next cycle IDLE with idx=0.
  - A digit_valid arriving in DONE is treated as the IDLE first digit (compared against EXP[0]), so back-to-back sequences lose no digits.
- ERROR:
  - error=1, busy=0; stays in ERROR until clear.
  - digit_valid is ignored.
- Latency: match asserts the cycle after the final valid digit is sampled; error asserts the cycle after the offending digit or the timeout expiry.
- busy=1 exactly in MATCHING. progress=idx, registered.
- Reset asserted mid-sequence aborts immediately to reset values, with no match or error pulse.
- Timer width is clog2(TIMEOUT_CYCLES)+1. The timer saturates and never wraps.

Decomposition:
- Shared package id_pkg holds:
  - state enum: IDLE=2'b00, MATCHING=2'b01, DONE=2'b10, ERROR=2'b11
  - err_code constants: ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT
  - ID_DIGITS constant array, shared with the sequencer so both ends stay in sync
- One sub-module, id_digit_rom: combinational index-to-expected-digit lookup (4-bit idx in, 4-bit digit out, 0 beyond N_DIGITS-1).
- Timer and FSM remain in the top module.

Test Plan:
- Feed 5,0,1,1,5,2,0,4,8 on consecutive cycles with valid=1 -> progress steps 1..8, match=1 for exactly one cycle after the 9th digit, error=0, then progress=0 and busy=0.
- Feed 5,0,1,3 -> error=1, err_code=01 the cycle after digit 3, progress=3 frozen; clear pulse -> error=0, progress=0, IDLE.
- Feed 5,0, then 15 idle cycles, then 1 -> no error, sequence continues. Feed 5,0, then 16 idle cycles -> error=1, err_code=10.
- Two full sequences back-to-back, with the first digit of the second in the DONE cycle -> two match pulses 9 cycles apart, no error.
- Drop reset low after 4 digits -> all outputs 0 immediately (async); after release, a full sequence -> match.
- clear and a mismatching digit_valid in the same MATCHING cycle -> IDLE, error=0 (clear wins); a valid digit while in ERROR -> ignored, outputs unchanged.
